// File: rtl/fetch_if_stage.sv
// ---------------------------------------------------------------------------------------------
// fetch_if_stage
//
// Instruction-fetch stage sitting directly upstream of decode. Owns the PC, issues fetches to
// instruction memory with at most one request outstanding (req/gnt/rvalid handshake), and
// loads the returned word together with its PC+4 into the IF/ID pipeline register.
// Decode can stall issue (hold_pc), freeze IF/ID (hold_if) and redirect the PC (br/pc_branch);
// wrong-path responses are dropped.
//
// Parameters:
//   RESET_PC     PC loaded on reset (low two bits forced to zero)
//   NOP_INST     word placed in IF/ID for bubbles and flushes
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   hold_pc      suppress issue of new fetch requests
//   hold_if      freeze the IF/ID register
//   br           instruction in IF/ID is a taken branch
//   pc_branch    branch target (low two bits discarded)
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid (in order, at least one cycle after grant)
//   imem_rdata   instruction word
//   inst_out     IF/ID instruction
//   pc_out       IF/ID PC+4 of inst_out
//   inst_valid   IF/ID holds a real instruction rather than a bubble
// ---------------------------------------------------------------------------------------------
module fetch_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_pc,
    input  logic        hold_if,
    input  logic        br,
    input  logic [31:0] pc_branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid
);

    // StReq   : may issue a request
    // StWait  : request granted, waiting for its response
    // StBuf   : response captured in the one-entry buffer while IF/ID is frozen
    // StDrain : request granted before a redirect; its response must be thrown away
    typedef enum logic [1:0] {
        StReq   = 2'd0,
        StWait  = 2'd1,
        StBuf   = 2'd2,
        StDrain = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_buf_inst;
    logic [31:0] w_buf_inst_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_pc_out;
    logic [31:0] w_pc_out_nxt;
    logic        r_valid;
    logic        w_valid_nxt;

    logic        w_issue;
    logic        w_redirect;
    logic        w_deliver;
    logic [31:0] w_deliver_word;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_unused;

    // The fetch PC stays put until its word is delivered, so r_pc is also the PC of the
    // outstanding or buffered word.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = {pc_branch[31:2], 2'b00};
    assign w_unused   = ^pc_branch[1:0];

    // A branch only counts when decode actually consumes a real instruction this cycle.
    assign w_redirect = br && !hold_if && r_valid;

    // ---------------------------------------------------------------------------------------
    // Handshake FSM, PC and buffer next-state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_buf_inst_nxt = r_buf_inst;
        w_issue        = 1'b0;
        w_deliver      = 1'b0;
        w_deliver_word = r_buf_inst;

        unique case (r_state)
            StReq: begin
                w_issue = !hold_pc && !rst;
                if (w_issue && imem_gnt) begin
                    // A redirect in the grant cycle makes the just-accepted fetch wrong-path.
                    w_state_nxt = w_redirect ? StDrain : StWait;
                end
            end

            StWait: begin
                if (w_redirect) begin
                    // If the response lands in the redirect cycle it is dropped right here;
                    // draining would wait for a response that never comes.
                    w_state_nxt = imem_rvalid ? StReq : StDrain;
                end else if (imem_rvalid) begin
                    if (hold_if) begin
                        w_buf_inst_nxt = imem_rdata;
                        w_state_nxt    = StBuf;
                    end else begin
                        w_deliver      = 1'b1;
                        w_deliver_word = imem_rdata;
                        w_state_nxt    = StReq;
                    end
                end
            end

            StBuf: begin
                if (w_redirect) begin
                    w_state_nxt = StReq;
                end else if (!hold_if) begin
                    w_deliver      = 1'b1;
                    w_deliver_word = r_buf_inst;
                    w_state_nxt    = StReq;
                end
            end

            StDrain: begin
                if (imem_rvalid) begin
                    w_state_nxt = StReq;
                end
            end

            default: begin
                w_state_nxt = StReq;
            end
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_redirect) begin
            w_pc_nxt = w_target;
        end else if (w_deliver) begin
            w_pc_nxt = w_pc_plus4;
        end
    end

    // ---------------------------------------------------------------------------------------
    // IF/ID register next-state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        w_inst_nxt   = r_inst;
        w_pc_out_nxt = r_pc_out;
        w_valid_nxt  = r_valid;
        if (!hold_if) begin
            // w_deliver is never set together with a redirect, so a flush wins here.
            if (w_deliver) begin
                w_inst_nxt   = w_deliver_word;
                w_pc_out_nxt = w_pc_plus4;
                w_valid_nxt  = 1'b1;
            end else begin
                w_inst_nxt  = NOP_INST;
                w_valid_nxt = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StReq;
            r_pc       <= {RESET_PC[31:2], 2'b00};
            r_buf_inst <= NOP_INST;
            r_inst     <= NOP_INST;
            r_pc_out   <= 32'h0000_0000;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_buf_inst <= w_buf_inst_nxt;
            r_inst     <= w_inst_nxt;
            r_pc_out   <= w_pc_out_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign imem_req   = w_issue;
    assign imem_addr  = {r_pc[31:2], 2'b00};
    assign inst_out   = r_inst;
    assign pc_out     = r_pc_out;
    assign inst_valid = r_valid;

endmodule

// File: tb/tb_fetch_if_stage.sv
// ---------------------------------------------------------------------------------------------
// tb_fetch_if_stage
//
// Directed bench for fetch_if_stage. A small memory responder grants every request (while
// gnt_en is set) and returns the request address as data after 1 or 2 cycles, or an override
// word. Deliveries into IF/ID are matched against a scoreboard queue filled by the directed
// steps; cycle-level checks cover stalls, redirects, wrap-around and reset.
// ---------------------------------------------------------------------------------------------
module tb_fetch_if_stage;

    logic        clk;
    logic        rst;
    logic        hold_pc;
    logic        hold_if;
    logic        br;
    logic [31:0] pc_branch;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;

    localparam logic [31:0] Nop = 32'h0000_0000;

    fetch_if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (Nop)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hold_pc     (hold_pc),
        .hold_if     (hold_if),
        .br          (br),
        .pc_branch   (pc_branch),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .inst_valid  (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder
    logic        gnt_en   = 1'b1;
    int          mem_lat  = 1;
    logic        ovr_en   = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    logic        rv1      = 1'b0;
    logic        rv2      = 1'b0;
    logic [31:0] d1       = 32'h0;
    logic [31:0] d2       = 32'h0;

    assign imem_gnt    = gnt_en;
    assign imem_rvalid = (mem_lat == 2) ? rv2 : rv1;
    assign imem_rdata  = (mem_lat == 2) ? d2 : d1;

    always @(posedge clk) begin
        rv1 <= imem_req && imem_gnt;
        d1  <= ovr_en ? ovr_data : imem_addr;
        rv2 <= rv1;
        d2  <= d1;
    end

    // Scoreboard
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic hold_at_edge = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        sb_q.push_back('{inst: inst, pc: pc});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic valid);
        chk({tag, "_inst"}, inst_out, inst);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_valid"}, 32'(inst_valid), 32'(valid));
    endtask

    // IF/ID was reloaded at the last edge only if hold_if was low during the cycle before it.
    always @(posedge clk) hold_at_edge <= hold_if;

    always @(negedge clk) begin
        if (!rst && !hold_at_edge && inst_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_delivery", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_inst", inst_out, mon_e.inst);
                chk("sb_pc", pc_out, mon_e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        hold_pc   = 1'b0;
        hold_if   = 1'b0;
        br        = 1'b0;
        pc_branch = 32'h0;

        // Reset state
        cyc();
        #1;
        chk_ifid("rst", Nop, 32'h0, 1'b0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        cyc();

        // Zero-wait streaming from 0: one delivery every other cycle
        cyc();
        rst = 1'b0;
        push(32'h0, 32'h4);
        push(32'h4, 32'h8);
        push(32'h8, 32'hC);
        push(32'hC, 32'h10);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) cyc();
            #1;
            chk("stream_valid", 32'(inst_valid), 32'((i >= 2) && (i % 2 == 0)));
            chk("stream_req", 32'(imem_req), 32'(i % 2 == 0));
            chk("stream_addr", imem_addr, 32'(4 * (i / 2)));
        end

        // Freeze 0xC in IF/ID while the 0x10 fetch is granted, then branch from WAIT
        cyc();
        hold_if = 1'b1;
        mem_lat = 2;
        #1;
        chk_ifid("pre_br", 32'hC, 32'h10, 1'b1);
        chk("pre_br_addr", imem_addr, 32'h10);
        cyc();
        hold_if   = 1'b0;
        br        = 1'b1;
        pc_branch = 32'h0000_0043;
        #1;
        chk("br_wait_req", 32'(imem_req), 32'd0);
        chk_ifid("br_wait_held", 32'hC, 32'h10, 1'b1);
        cyc();
        br = 1'b0;
        #1;
        chk("br_flush_inst", inst_out, Nop);
        chk("br_flush_valid", 32'(inst_valid), 32'd0);
        chk("br_drain_req", 32'(imem_req), 32'd0);
        chk("br_target_addr", imem_addr, 32'h40);
        cyc();
        mem_lat = 1;
        push(32'h40, 32'h44);
        #1;
        chk("br_refetch_req", 32'(imem_req), 32'd1);
        chk("br_refetch_addr", imem_addr, 32'h40);
        chk("br_dropped_valid", 32'(inst_valid), 32'd0);
        cyc();
        #1;
        chk("wait40_req", 32'(imem_req), 32'd0);

        // Response arrives while IF/ID is frozen for 3 cycles; a branch during the hold is ignored
        cyc();
        hold_if  = 1'b1;
        ovr_en   = 1'b1;
        ovr_data = 32'h8C22_0004;
        #1;
        chk_ifid("hold_start", 32'h40, 32'h44, 1'b1);
        chk("hold_start_addr", imem_addr, 32'h44);
        cyc();
        ovr_en = 1'b0;
        #1;
        chk_ifid("frozen1", 32'h40, 32'h44, 1'b1);
        chk("frozen1_req", 32'(imem_req), 32'd0);
        cyc();
        br        = 1'b1;
        pc_branch = 32'h0000_0100;
        #1;
        chk_ifid("frozen2", 32'h40, 32'h44, 1'b1);
        chk("frozen2_req", 32'(imem_req), 32'd0);
        cyc();
        br      = 1'b0;
        hold_if = 1'b0;
        push(32'h8C22_0004, 32'h48);
        #1;
        chk_ifid("frozen3", 32'h40, 32'h44, 1'b1);
        chk("frozen3_req", 32'(imem_req), 32'd0);
        chk("br_held_ignored_addr", imem_addr, 32'h44);

        // Released buffer word; then redirect to 0xFFFFFFFF in a grant cycle
        cyc();
        br        = 1'b1;
        pc_branch = 32'hFFFF_FFFF;
        #1;
        chk_ifid("released", 32'h8C22_0004, 32'h48, 1'b1);
        chk("released_addr", imem_addr, 32'h48);
        chk("released_req", 32'(imem_req), 32'd1);
        cyc();
        br = 1'b0;
        #1;
        chk("br_req_flush_valid", 32'(inst_valid), 32'd0);
        chk("br_req_flush_inst", inst_out, Nop);
        chk("br_req_drain_req", 32'(imem_req), 32'd0);
        chk("br_align_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        push(32'hFFFF_FFFC, 32'h0);
        #1;
        chk("wrap_req", 32'(imem_req), 32'd1);
        chk("wrap_fetch_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        cyc();
        #1;
        chk_ifid("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1);
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Reset while in WAIT; the stale response lands in the release cycle
        cyc();
        mem_lat = 2;
        rst     = 1'b1;
        #1;
        chk_ifid("mid_rst", Nop, 32'h0, 1'b0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        cyc();
        rst = 1'b0;
        push(32'h0, 32'h4);
        #1;
        chk("stray_rvalid_present", 32'(imem_rvalid), 32'd1);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        cyc();
        #1;
        chk("stray_dropped_valid", 32'(inst_valid), 32'd0);
        chk("post_rst_wait_req", 32'(imem_req), 32'd0);
        cyc();
        cyc();
        gnt_en = 1'b0;
        #1;
        chk_ifid("post_rst_first", 32'h0, 32'h4, 1'b1);

        // No grant: request stays up at the same address
        cyc();
        cyc();
        cyc();
        #1;
        chk("nogrant_req", 32'(imem_req), 32'd1);
        chk("nogrant_addr", imem_addr, 32'h4);
        chk("nogrant_valid", 32'(inst_valid), 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
